// File: rtl/afifo_pkg.sv
// Shared definitions for the afifo write-side arbiter: FSM encoding and default data width.
package afifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int AFIFODW_DEF = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after rr_ptr_i, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   pick_idx_o,
  output logic            any_o
);

  always_comb begin
    int c;
    pick_o     = '0;
    pick_idx_o = '0;
    any_o      = 1'b0;
    c          = 0;
    // Offsets 1..NREQ: the last-served requester is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(rr_ptr_i) + k) % NREQ;
      if (req_i[c[IW-1:0]] && !any_o) begin
        any_o              = 1'b1;
        pick_o[c[IW-1:0]]  = 1'b1;
        pick_idx_o         = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin, packet-locked arbiter sharing one afifo write port; 1-cycle arbitration bubble,
// beats pass combinationally while granted, wqfull stalls the granted requester with all state held.
module afifo_wr_arb
  import afifo_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AFIFODW = AFIFODW_DEF,
  parameter int MAXBEAT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*AFIFODW-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wqfull,
  output logic                    wen,
  output logic [AFIFODW-1:0]      wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  input  logic                    err_clr,
  output logic                    err_overrun
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAXBEAT);
  localparam logic [BW-1:0] CNT_MAX = BW'(MAXBEAT - 1);

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   gnt_idx_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [BW-1:0]   beat_cnt_q;
  logic            err_q;
  logic            err_d;

  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic            accept;
  logic            last_g;
  logic            overrun;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i      (req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx),
    .any_o      (pick_any)
  );

  // gnt_q is only non-zero in GRANT, so masking with it also qualifies the state.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        wdata = wdata | req_data[i*AFIFODW +: AFIFODW];
      end
    end
  end

  assign last_g    = |(gnt_q & req_last);
  assign accept    = (state_q == ST_GRANT) && (|(gnt_q & req_valid)) && !wqfull;
  assign overrun   = accept && !last_g && (beat_cnt_q == CNT_MAX);
  assign req_ready = ((state_q == ST_GRANT) && !wqfull) ? gnt_q : '0;
  assign wen       = accept;
  assign gnt       = gnt_q;
  assign busy      = (state_q == ST_GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= IW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_q      <= pick;
            gnt_idx_q  <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (accept) begin
            // Forced release at MAXBEAT: the tail of the packet re-arbitrates as a new packet.
            if (last_g || (beat_cnt_q == CNT_MAX)) begin
              state_q  <= ST_IDLE;
              gnt_q    <= '0;
              rr_ptr_q <= gnt_idx_q;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A new overrun wins over a simultaneous clear.
  assign err_d = overrun ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_overrun = err_q;

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Directed scenarios plus randomized traffic for afifo_wr_arb, checked cycle by cycle against a packet-level model.
module tb_afifo_wr_arb;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int MB = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           wqfull;
  logic           wen;
  logic [W-1:0]   wdata;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           err_clr;
  logic           err_overrun;

  afifo_wr_arb #(.NREQ(N), .AFIFODW(W), .MAXBEAT(MB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wqfull      (wqfull),
    .wen         (wen),
    .wdata       (wdata),
    .gnt         (gnt),
    .busy        (busy),
    .err_clr     (err_clr),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Source queues: one packet beat per entry.
  logic [W-1:0] qd[N][$];
  logic         ql[N][$];

  // Packet-level reference: current owner (-1 idle), last served, beats taken, sticky error.
  int   m_own;
  int   m_last;
  int   m_cnt;
  logic m_err;

  // Observed logs.
  int           n_wen;
  logic [W-1:0] wlog[$];
  int           glog[$];
  logic [N-1:0] prev_gnt;

  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic void model_reset();
    m_own    = -1;
    m_last   = N - 1;
    m_cnt    = 0;
    m_err    = 1'b0;
    prev_gnt = '0;
  endfunction

  function automatic void clear_logs();
    n_wen = 0;
    wlog.delete();
    glog.delete();
  endfunction

  function automatic void push_pkt(int r, int nbeats, logic [W-1:0] base);
    for (int b = 0; b < nbeats; b++) begin
      qd[r].push_back(base + W'(b));
      ql[r].push_back(b == nbeats - 1);
    end
  endfunction

  function automatic bit pending();
    bit p;
    p = (m_own >= 0);
    for (int i = 0; i < N; i++) if (qd[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // One clock cycle: drive, check mid-cycle, advance model and sources.
  task automatic cyc(input logic [N-1:0] en, input logic fq, input logic clr);
    logic [N-1:0] v, l, e_gnt, e_rdy;
    logic [N*W-1:0] d;
    logic         e_wen;
    logic [W-1:0] e_wd;
    logic         set;
    int           pk, c, o, gi;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (qd[i].size() > 0) begin
        v[i] = en[i];
        l[i] = ql[i][0];
        d[i*W +: W] = qd[i][0];
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
    wqfull    = fq;
    err_clr   = clr;
    #3;
    e_gnt = '0;
    if (m_own >= 0) e_gnt[m_own] = 1'b1;
    e_wen = (m_own >= 0) && v[m_own] && !fq;
    e_rdy = ((m_own >= 0) && !fq) ? e_gnt : '0;
    e_wd  = (m_own >= 0) ? d[m_own*W +: W] : '0;
    chk("gnt", gnt, e_gnt);
    chk("busy", busy, m_own >= 0);
    chk("req_ready", req_ready, e_rdy);
    chk("wen", wen, e_wen);
    chk("wdata", wdata, e_wd);
    chk("err_overrun", err_overrun, m_err);
    if (wen === 1'b1) begin
      n_wen++;
      wlog.push_back(wdata);
    end
    if (gnt !== '0 && prev_gnt === '0) begin
      gi = -1;
      for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) gi = i;
      glog.push_back(gi);
    end
    prev_gnt = gnt;
    set = 1'b0;
    if (m_own < 0) begin
      pk = -1;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (pk < 0 && v[c]) pk = c;
      end
      if (pk >= 0) begin
        m_own = pk;
        m_cnt = 0;
      end
    end else if (e_wen) begin
      o = m_own;
      void'(qd[o].pop_front());
      void'(ql[o].pop_front());
      if (l[o]) begin
        m_last = o;
        m_own  = -1;
      end else if (m_cnt == MB - 1) begin
        m_last = o;
        m_own  = -1;
        set    = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    if (set) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    int b;
    b = 0;
    while (pending() && b < budget) begin
      cyc('1, 1'b0, 1'b0);
      b++;
    end
    chk("drain_idle", {busy, gnt}, '0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", gnt, '0);
    chk("rst_wen", wen, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, '0);
    chk("rst_wdata", wdata, '0);
    chk("rst_err", err_overrun, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wqfull    = 1'b0;
    err_clr   = 1'b0;
    model_reset();
    clear_logs();
    #3;
    chk("rst_gnt", gnt, '0);
    chk("rst_wen", wen, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wdata", wdata, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single 4-beat packet from requester 0.
    clear_logs();
    push_pkt(0, 4, 32'h11);
    run_until_idle(50);
    chk("s1_wen_count", n_wen, 4);
    for (int i = 0; i < 4; i++) chk("s1_wdata", wlog[i], 32'h11 + i);
    chk("s1_grant", glog[0], 0);

    // Two requesters alternating single-beat packets.
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 1, 32'h100 + i);
      push_pkt(1, 1, 32'h200 + i);
    end
    run_until_idle(100);
    chk("s2_wen_count", n_wen, 8);
    chk("s2_grants", glog.size(), 8);
    for (int i = 0; i < 8; i++) chk("s2_order", glog[i], i % 2);

    // wqfull during beats 2-3 of a requester 1 packet.
    clear_logs();
    push_pkt(1, 3, 32'h31);
    cyc('1, 1'b0, 1'b0);
    cyc('1, 1'b0, 1'b0);
    cyc('1, 1'b1, 1'b0);
    cyc('1, 1'b1, 1'b0);
    run_until_idle(50);
    chk("s3_wen_count", n_wen, 3);
    for (int i = 0; i < 3; i++) chk("s3_wdata", wlog[i], 32'h31 + i);

    // Oversized packet forces a release and raises the sticky error.
    clear_logs();
    push_pkt(0, 10, 32'hA0);
    run_until_idle(100);
    chk("s4_wen_count", n_wen, 10);
    chk("s4_regrants", glog.size(), 2);
    chk("s4_err_set", err_overrun, 1'b1);
    cyc('1, 1'b0, 1'b1);
    chk("s4_err_clr", err_overrun, 1'b0);

    // Reset after beat 2 of a 4-beat packet; requester 0 must win the subsequent tie.
    push_pkt(0, 4, 32'h51);
    cyc('1, 1'b0, 1'b0);
    cyc('1, 1'b0, 1'b0);
    cyc('1, 1'b0, 1'b0);
    do_reset();
    clear_logs();
    push_pkt(1, 1, 32'h61);
    run_until_idle(50);
    chk("s5_first_grant", glog[0], 0);
    chk("s5_second_grant", glog[1], 1);
    chk("s5_wen_count", n_wen, 3);

    // Valid gap mid-packet holds the grant against a waiting requester.
    do_reset();
    clear_logs();
    push_pkt(0, 4, 32'h71);
    push_pkt(1, 2, 32'h81);
    cyc('1, 1'b0, 1'b0);
    cyc('1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(3'b110, 1'b0, 1'b0);
    run_until_idle(50);
    chk("s6_grants", glog.size(), 2);
    chk("s6_first", glog[0], 0);
    chk("s6_second", glog[1], 1);
    chk("s6_handoff", wlog[4], 32'h81);

    // Randomized traffic, stalls, gaps and clears.
    for (int t = 0; t < 600; t++) begin
      logic [N-1:0] en;
      for (int i = 0; i < N; i++) begin
        if (qd[i].size() < 6 && ($urandom % 6) == 0)
          push_pkt(i, int'($urandom_range(1, 12)), $urandom);
        en[i] = (($urandom % 5) != 0);
      end
      cyc(en, (($urandom % 4) == 0), (($urandom % 16) == 0));
    end
    run_until_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/afifo_wr_arb.md
Name: afifo_wr_arb

Overview:
- Shares the write port of one afifo instance among NREQ requesters, for example several AXI channel engines feeding one command/data FIFO toward the MIG clock domain.
- Round-robin arbitration with packet locking: a granted requester keeps the port until its last beat is written.
- Honours afifo wqfull backpressure.
- Enforces a maximum packet length, with a sticky error flag.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AFIFODW, 32, data width; must equal the afifo data width.
- MAXBEAT, 8, maximum beats per packet before forced release (2..16).

Ports:
- clk  in  1  write-side clock; the same clock as afifo wclk.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_last  in  NREQ  per-requester last beat of packet.
- req_data  in  NREQ*AFIFODW  per-requester data; requester i occupies bits [i*AFIFODW +: AFIFODW].
- req_ready  out  NREQ  beat accepted this cycle when req_valid & req_ready.
- wqfull  in  1  afifo full flag.
- wen  out  1  afifo write enable.
- wdata  out  AFIFODW  afifo write data.
- gnt  out  NREQ  registered one-hot grant; all zeros when idle.
- busy  out  1  state == GRANT.
- err_clr  in  1  single-cycle pulse; clears err_overrun.
- err_overrun  out  1  sticky; a packet exceeded MAXBEAT.

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, rr_ptr=NREQ-1, beat_cnt=0, err_overrun=0. All outputs are 0: wen, wdata, req_ready, busy.
- States: IDLE and GRANT, registered.
- IDLE:
  - If any req_valid is high, pick the first requesting index scanning from rr_ptr+1 upward, modulo NREQ.
  - Next edge: gnt<=onehot(pick), beat_cnt<=0, state<=GRANT.
  - No beat is accepted in IDLE (req_ready=0). This gives a 1-cycle arbitration bubble.
- GRANT:
  - req_ready[i] = gnt[i] & ~wqfull. This is combinational.
  - accept = |(gnt & req_valid) & ~wqfull.
  - wen = accept.
  - wdata = slice of the granted requester; 0 when gnt==0.
- GRANT, on accept with last of the granted requester = 1:
  - state<=IDLE, gnt<=0, rr_ptr<=granted index.
- GRANT, on accept with last=0 and beat_cnt==MAXBEAT-1:
  - Forced release: state<=IDLE, gnt<=0, rr_ptr<=granted index, err_overrun<=1.
  - The remaining beats of that packet are re-arbitrated as a new packet.
- GRANT, on accept otherwise: beat_cnt<=beat_cnt+1.
- Valid gap mid-packet (granted req_valid=0): hold grant and beat_cnt. There is no timeout.
- wqfull=1: req_ready=0, wen=0, all state held. Resumes the first cycle wqfull=0.
- Non-granted requesters always see req_ready=0. Their req_valid changes have no effect until IDLE.
- Minimum packet (single beat, last=1): 2 cycles per packet (arbitrate + write). Back-to-back packets from different requesters have 1 idle cycle between them.
- beat_cnt width is $clog2(MAXBEAT). It never wraps, because release occurs at MAXBEAT-1.
- err_clr and a new overrun in the same cycle: set wins.
- Reset mid-packet: immediate clear. Any partial packet already written to the afifo is not retracted; the consumer must tolerate it.

Decomposition:
- Shared package/include afifo_pkg: the state encoding localparams (ST_IDLE=1'b0, ST_GRANT=1'b1) and the default AFIFODW.
- One combinational sub-module, rr_pick. Inputs: req vector and rr_ptr. Outputs: one-hot pick and its index.
- Keeping rr_pick separate lets it be reused by a future read-side scheduler.

Test Plan:
- Req0 only, 4-beat packet, data 0x11..0x14, last on beat 4 -> gnt=01 one cycle after valid; wen high 4 consecutive cycles with wdata 0x11..0x14; then gnt=00 and busy=0.
- Req0 and req1 both valid from reset, 1-beat packets each, repeated 4 times -> grant order 0,1,0,1; a 1-cycle gap between writes; no requester is granted twice in a row.
- Req1 granted, wqfull=1 on beats 2-3 of a 3-beat packet -> wen=0 and req_ready[1]=0 during full; beat 2 data is written on the first cycle wqfull=0; total wen count=3.
- MAXBEAT=8, req0 sends 10 beats with last on beat 10 -> 8 writes, then release and err_overrun=1; after re-arbitration the remaining 2 beats are written; err_clr pulse -> err_overrun=0 next cycle.
- Reset asserted after beat 2 of a 4-beat packet -> gnt=0, wen=0 and state=IDLE immediately; after release, the next grant starts with rr_ptr=NREQ-1, i.e. req0 wins a tie.
- Req0 drops valid for 3 cycles mid-packet while req1 is valid -> gnt stays 01; req1 is not served until req0's last beat is accepted.
